// File: rtl/morse_pkg.sv
// Shared definitions for the Morse message scheduler.
//   - letter index constants (Q..X map to 0..7)
//   - per-letter element code (left-aligned, first element in bit 3, 1 = dash)
//     and element count
//   - unit counts for marks and gaps
//   - scheduler FSM state encoding
package morse_pkg;

   localparam logic [2:0] L_Q = 3'd0;
   localparam logic [2:0] L_R = 3'd1;
   localparam logic [2:0] L_S = 3'd2;
   localparam logic [2:0] L_T = 3'd3;
   localparam logic [2:0] L_U = 3'd4;
   localparam logic [2:0] L_V = 3'd5;
   localparam logic [2:0] L_W = 3'd6;
   localparam logic [2:0] L_X = 3'd7;

   localparam int unsigned DOT_U        = 1;
   localparam int unsigned DASH_U       = 3;
   localparam int unsigned ELEM_GAP_U   = 1;
   localparam int unsigned LETTER_GAP_U = 3;
   localparam int unsigned WORD_GAP_U   = 7;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MARK,
      SPACE,
      LGAP,
      WGAP
   } state_t;

   // Unused trailing bits are zero; only the first letter_len() bits matter.
   function automatic logic [3:0] letter_code(input logic [2:0] idx);
      logic [3:0] code;
      case (idx)
         L_Q:     code = 4'b1101;
         L_R:     code = 4'b0100;
         L_S:     code = 4'b0000;
         L_T:     code = 4'b1000;
         L_U:     code = 4'b0010;
         L_V:     code = 4'b0001;
         L_W:     code = 4'b0110;
         default: code = 4'b1001;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] letter_len(input logic [2:0] idx);
      logic [2:0] len;
      case (idx)
         L_Q, L_V, L_X: len = 3'd4;
         L_T:           len = 3'd1;
         default:       len = 3'd3;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/morse_fifo.sv
// Circular DEPTH x 4 entry queue for the Morse scheduler.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   flush          synchronous clear of contents and overflow; wins over push/pop
//   push, wr_data  enqueue request and entry
//   pop            dequeue request (ignored when empty)
//   rd_data        head entry (valid when not empty)
//   full, empty    occupancy flags
//   level          current entry count
//   overflow       sticky: a push was dropped while full
module morse_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LVL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [3:0]       wr_data,
   input  logic             pop,
   output logic [3:0]       rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             overflow
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   // Full means dropped, even if a pop frees a slot in the same cycle.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && full) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/morse_msg_scheduler.sv
// Message-level Morse lamp controller: queues letter indices and word-space
// tokens, expands each entry to timed marks/gaps and drives one lamp.
// Ports:
//   CLOCK_50          system clock
//   reset             asynchronous active-high reset
//   wr_en, wr_data    push entry ([3]=1 word space, else letter index [2:0])
//   run               allow new entries to start
//   abort             synchronous flush of queue and output
//   full, empty       queue flags
//   level, overflow   queue count and sticky drop flag
//   lamp              Morse output, 1 = mark
//   busy              scheduler not idle
//   cur_letter        index of the letter being / last sent
//   letter_done       one-cycle pulse after an entry's trailing gap
module morse_msg_scheduler
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 25000000,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned LVL_W       = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [3:0]       wr_data,
   input  logic             run,
   input  logic             abort,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             overflow,
   output logic             lamp,
   output logic             busy,
   output logic [2:0]       cur_letter,
   output logic             letter_done
);

   localparam int unsigned         TW      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [TW-1:0]       TICK_AT = TW'(UNIT_CYCLES - 1);
   localparam logic [2:0]          DOT     = 3'(DOT_U);
   localparam logic [2:0]          DASH    = 3'(DASH_U);

   state_t        state;
   logic [TW-1:0] timer;
   logic          tick;
   logic [2:0]    units;     // units left in the current interval
   logic [3:0]    code;      // current element in bit 3
   logic [2:0]    rem;       // elements left after the current one
   logic [3:0]    entry;     // popped queue entry awaiting LOAD
   logic          done_pend;
   logic          pop;
   logic [3:0]    rd_data;
   logic [3:0]    ld_code;

   assign tick    = (timer == TICK_AT);
   assign pop     = (state == IDLE) && run && !empty && !abort;
   assign busy    = (state != IDLE);
   assign ld_code = letter_code(entry[2:0]);

   morse_fifo #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk      (CLOCK_50),
      .reset    (reset),
      .flush    (abort),
      .push     (wr_en),
      .wr_data  (wr_data),
      .pop      (pop),
      .rd_data  (rd_data),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         units       <= '0;
         code        <= '0;
         rem         <= '0;
         entry       <= '0;
         done_pend   <= 1'b0;
         lamp        <= 1'b0;
         letter_done <= 1'b0;
         cur_letter  <= '0;
      end else if (abort) begin
         state       <= IDLE;
         timer       <= '0;
         done_pend   <= 1'b0;
         lamp        <= 1'b0;
         letter_done <= 1'b0;
      end else begin
         // lamp and letter_done both lag the state by one cycle, so the
         // trailing gap seen on lamp is the full gap before the pulse.
         lamp        <= (state == MARK);
         letter_done <= done_pend;
         done_pend   <= 1'b0;
         timer       <= tick ? '0 : timer + 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  entry <= rd_data;
                  state <= LOAD;
                  timer <= '0;
               end
            end
            LOAD: begin
               timer <= '0;
               if (entry[3]) begin
                  units <= 3'(WORD_GAP_U);
                  state <= WGAP;
               end else begin
                  cur_letter <= entry[2:0];
                  code       <= ld_code;
                  rem        <= letter_len(entry[2:0]) - 3'd1;
                  units      <= ld_code[3] ? DASH : DOT;
                  state      <= MARK;
               end
            end
            MARK: begin
               if (tick) begin
                  if (units == 3'd1) begin
                     timer <= '0;
                     if (rem != '0) begin
                        units <= 3'(ELEM_GAP_U);
                        state <= SPACE;
                     end else begin
                        units <= 3'(LETTER_GAP_U);
                        state <= LGAP;
                     end
                  end else begin
                     units <= units - 3'd1;
                  end
               end
            end
            SPACE: begin
               if (tick) begin
                  if (units == 3'd1) begin
                     timer <= '0;
                     code  <= {code[2:0], 1'b0};
                     rem   <= rem - 3'd1;
                     units <= code[2] ? DASH : DOT;
                     state <= MARK;
                  end else begin
                     units <= units - 3'd1;
                  end
               end
            end
            LGAP, WGAP: begin
               if (tick) begin
                  if (units == 3'd1) begin
                     timer     <= '0;
                     done_pend <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     units <= units - 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_msg_scheduler.sv
module tb_morse_msg_scheduler;

   localparam int U = 4;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [3:0] wr_data;
   logic       run;
   logic       abort;
   logic       full;
   logic       empty;
   logic [3:0] level;
   logic       overflow;
   logic       lamp;
   logic       busy;
   logic [2:0] cur_letter;
   logic       letter_done;

   morse_msg_scheduler #(
      .UNIT_CYCLES (U),
      .DEPTH       (8),
      .LVL_W       (4)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .run         (run),
      .abort       (abort),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .overflow    (overflow),
      .lamp        (lamp),
      .busy        (busy),
      .cur_letter  (cur_letter),
      .letter_done (letter_done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Letter table Q..X, independent of the RTL package.
   string pat [8] = '{"--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-"};

   // Scoreboard: mark widths and letter_done cur_letter values (-1 = word token).
   int exp_w[$];
   int exp_l[$];
   int start_gaps[$];
   int done_lows[$];

   int cyc = 0;
   int last_fall = 0;
   int last_rise = 0;
   int first_rise = 0;
   int done_cnt = 0;
   int rise_cnt = 0;
   int last_span = 0;
   bit prev = 1'b0;
   bit letter_start = 1'b1;
   bit abort_d = 1'b0;

   always @(negedge CLOCK_50) begin
      cyc++;
      if (reset) begin
         prev         = 1'b0;
         letter_start = 1'b1;
         abort_d      = 1'b0;
      end else begin
         if (lamp && !prev) begin
            rise_cnt++;
            if (letter_start) begin
               start_gaps.push_back(cyc - last_fall);
               first_rise   = cyc;
               letter_start = 1'b0;
            end else begin
               check_eq("elem_gap", cyc - last_fall, U);
            end
            last_rise = cyc;
         end
         if (!lamp && prev) begin
            if (!abort_d) begin
               if (exp_w.size() == 0) check_eq("mark_unexpected", cyc - last_rise, -1);
               else check_eq("mark_width", cyc - last_rise, exp_w.pop_front());
            end
            last_fall = cyc;
         end
         if (letter_done) begin
            int e;
            done_cnt++;
            done_lows.push_back(cyc - last_fall);
            last_span = cyc - first_rise;
            if (exp_l.size() == 0) begin
               check_eq("done_unexpected", done_cnt, -1);
            end else begin
               e = exp_l.pop_front();
               if (e >= 0) check_eq("done_cur_letter", int'(cur_letter), e);
            end
            letter_start = 1'b1;
         end
         abort_d = abort;
         if (abort) letter_start = 1'b1;
         prev = lamp;
      end
   end

   task automatic push_entry(input logic [3:0] d, input bit accept);
      int idx;
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) begin
         if (d[3]) begin
            exp_l.push_back(-1);
         end else begin
            idx = int'(d[2:0]);
            exp_l.push_back(idx);
            for (int i = 0; i < pat[idx].len(); i++) begin
               exp_w.push_back((pat[idx][i] == "-") ? 3 * U : U);
            end
         end
      end
      @(posedge CLOCK_50);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) @(posedge CLOCK_50);
      #1;
      check_eq("done_count", done_cnt, target);
   endtask

   task automatic wait_rise(input int target, input int budget);
      for (int i = 0; i < budget && rise_cnt < target; i++) @(posedge CLOCK_50);
      #1;
      check_eq("rise_count", rise_cnt, target);
   endtask

   initial begin
      int base;
      int rbase;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      run     = 1'b0;
      abort   = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check_eq("rst_lamp", int'(lamp), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_empty", int'(empty), 1);
      check_eq("rst_full", int'(full), 0);
      check_eq("rst_level", int'(level), 0);
      check_eq("rst_overflow", int'(overflow), 0);
      check_eq("rst_done", int'(letter_done), 0);
      check_eq("rst_cur", int'(cur_letter), 0);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;

      // T: 3 units on, 3 units off, then the pulse.
      run = 1'b1;
      push_entry(4'd3, 1'b1);
      wait_done(1, 200);
      check_eq("t_trailing_low", done_lows[0], 3 * U);
      check_eq("t_busy", int'(busy), 0);
      check_eq("t_cur", int'(cur_letter), 3);
      check_eq("t_done_pulse", int'(letter_done), 0);

      // S: 3 dots, 2 element gaps, letter gap.
      push_entry(4'd2, 1'b1);
      wait_done(2, 200);
      check_eq("s_span", last_span, 8 * U);
      check_eq("s_trailing_low", done_lows[1], 3 * U);

      // Q, word space, U back to back.
      done_lows.delete();
      start_gaps.delete();
      push_entry(4'd0, 1'b1);
      push_entry(4'b1000, 1'b1);
      push_entry(4'd4, 1'b1);
      wait_done(5, 800);
      check_eq("w_token_low", done_lows[1], 3 * U + 2 + 7 * U);
      check_eq("w_u_start_gap", start_gaps[start_gaps.size() - 1], 3 * U + 2 + 7 * U + 2);
      check_eq("w_cur", int'(cur_letter), 4);

      // Overflow with run low: ninth push dropped.
      run = 1'b0;
      for (int i = 0; i < 9; i++) push_entry({1'b0, 3'(i % 8)}, i < 8);
      check_eq("ovf_full", int'(full), 1);
      check_eq("ovf_level", int'(level), 8);
      check_eq("ovf_flag", int'(overflow), 1);
      check_eq("ovf_lamp", int'(lamp), 0);
      check_eq("ovf_busy", int'(busy), 0);
      run = 1'b1;
      wait_done(13, 1200);
      check_eq("ovf_drain_empty", int'(empty), 1);
      check_eq("ovf_sticky", int'(overflow), 1);
      check_eq("ovf_marks_left", exp_w.size(), 0);

      // Abort during the second dash of W with 3 entries queued.
      rbase = rise_cnt;
      push_entry(4'd6, 1'b1);
      push_entry(4'd1, 1'b1);
      push_entry(4'd2, 1'b1);
      push_entry(4'd3, 1'b1);
      wait_rise(rbase + 3, 300);
      @(posedge CLOCK_50);
      #1;
      abort   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 4'd3;
      exp_w.delete();
      exp_l.delete();
      base = done_cnt;
      @(posedge CLOCK_50);
      #1;
      abort = 1'b0;
      wr_en = 1'b0;
      check_eq("ab_lamp", int'(lamp), 0);
      check_eq("ab_empty", int'(empty), 1);
      check_eq("ab_level", int'(level), 0);
      check_eq("ab_overflow", int'(overflow), 0);
      check_eq("ab_busy", int'(busy), 0);
      check_eq("ab_done", int'(letter_done), 0);
      repeat (60) @(posedge CLOCK_50);
      #1;
      check_eq("ab_no_done", done_cnt, base);
      check_eq("ab_no_rise", rise_cnt, rbase + 3);

      // Asynchronous reset mid-mark, then a normal R.
      rbase = rise_cnt;
      push_entry(4'd3, 1'b1);
      wait_rise(rbase + 1, 100);
      repeat (3) @(posedge CLOCK_50);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_lamp", int'(lamp), 0);
      check_eq("arst_busy", int'(busy), 0);
      exp_w.delete();
      exp_l.delete();
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      check_eq("arst_cur", int'(cur_letter), 0);
      base = done_cnt;
      push_entry(4'd1, 1'b1);
      wait_done(base + 1, 300);
      check_eq("r_span", last_span, 10 * U);
      check_eq("r_cur", int'(cur_letter), 1);
      check_eq("r_marks_left", exp_w.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_msg_scheduler.md
Name: morse_msg_scheduler

Overview:
- Message-level controller for the Morse lamp output.
- Buffers a queue of letter indices (0..7 = Q,R,S,T,U,V,W,X) and word-space tokens.
- Pops one entry at a time, expands it to dot/dash marks with standard unit timing, and drives a single lamp output (LEDR-class).
- Sits between switch/key front-end logic and the lamp; replaces per-letter manual triggering.

Parameters:
UNIT_CYCLES, 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); set small (e.g. 4) in simulation
DEPTH, 8, queue entries; power of two, >= 2
LVL_W, 4, width of level output = log2(DEPTH)+1

Ports:
CLOCK_50  in   1      system clock, all logic on rising edge
reset     in   1      asynchronous, active-high reset
wr_en     in   1      push wr_data into queue this cycle
wr_data   in   4      [3]=1: word-space token ([2:0] ignored); [3]=0: letter index [2:0]
run       in   1      1 = scheduler may start new entries; 0 = finish current entry then hold
abort     in   1      synchronous flush: empty queue, stop output, clear overflow
full      out  1      queue holds DEPTH entries
empty     out  1      queue holds 0 entries
level     out  LVL_W  current entry count
overflow  out  1      sticky: a push was dropped while full
lamp      out  1      Morse output, 1 = mark
busy      out  1      1 whenever state != IDLE
cur_letter out 3      index of the entry being sent (held after completion)
letter_done out 1     one-cycle pulse when an entry's trailing gap completes

Behaviour:
- Reset: queue empty, state IDLE, lamp=0, busy=0, overflow=0, letter_done=0, cur_letter=0, unit timer=0. All outputs registered.
- Letter table (MSB first, 1=dash):
  - Q --.- len4; R .-. len3; S ... len3; T - len1
  - U ..- len3; V ...- len4; W .-- len3; X -..- len4
- Timing:
  - dot = 1 unit on; dash = 3 units on
  - inter-element gap = 1 unit off
  - after a letter's last element: 3 units off
  - word-space token: 7 units off
- Unit timer:
  - Counts 0..UNIT_CYCLES-1 and wraps, producing a tick on the wrap cycle.
  - Cleared on every state entry, so each interval is exactly N*UNIT_CYCLES cycles.
- States: IDLE, LOAD, MARK, SPACE, LGAP, WGAP.
  - IDLE: lamp=0. If run && !empty: pop head (same cycle), go LOAD.
  - LOAD (1 cycle): latch code, length and cur_letter from the popped entry.
    - Word-space token -> WGAP with remaining units = 7.
    - Letter -> MARK with units = 3 (dash) or 1 (dot) from the head bit.
  - MARK: lamp=1. Decrement units on tick. When units reach 0:
    - elements remaining -> SPACE (1 unit)
    - otherwise -> LGAP (3 units)
  - SPACE: lamp=0; after 1 unit -> MARK with the next element.
  - LGAP/WGAP: lamp=0; after the gap expires, pulse letter_done and go to IDLE.
  - The next pop can occur in the IDLE cycle that follows.
- lamp is registered: it rises the cycle after entering MARK and falls the cycle after leaving MARK. A dot mark is exactly UNIT_CYCLES cycles high.
- run=0 mid-entry: the current entry, including its trailing gap, completes; the scheduler then stays in IDLE.
- Queue:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Push while full: data dropped, overflow set, pointers unchanged.
  - Push and pop in the same cycle while not full: both happen; level unchanged.
  - Push while full is dropped even if a pop occurs in the same cycle.
- abort (highest priority over push, pop and FSM):
  - Next cycle: queue empty, state IDLE, lamp=0, overflow=0, no letter_done.
  - A wr_en in the abort cycle is ignored.
- Asynchronous reset mid-letter forces the reset values immediately.

Decomposition:
- Shared package morse_pkg:
  - letter-index constants (L_Q..L_X)
  - 4-bit code and 3-bit length table as constant functions
  - unit counts DOT_U=1, DASH_U=3, ELEM_GAP_U=1, LETTER_GAP_U=3, WORD_GAP_U=7
  - FSM state encodings
- One sub-module: morse_fifo (DEPTH x 4 circular buffer providing full, empty, level and overflow).
- FSM and unit timer stay in the top module.

Test Plan:
- UNIT_CYCLES=4; push T, run=1 -> lamp high 12 cycles, low 12 cycles, letter_done pulse, busy drops, cur_letter=3.
- Push S -> lamp pattern 4 on / 4 off / 4 on / 4 off / 4 on / 12 off; total 32 cycles from first lamp rise to letter_done.
- Push Q, word-space token, U with run=1 -> Q (--.-), then 28 lamp-off cycles from the word token, then U (..-); three letter_done pulses; cur_letter after the token shows 4.
- run=0, push 9 entries into DEPTH=8 -> full=1, level=8, overflow=1, lamp stays 0. Then run=1 -> exactly 8 entries emitted in push order.
- Abort during the second dash of W with 3 entries queued -> next cycle lamp=0, empty=1, level=0, overflow=0, busy=0; no letter_done.
- Assert reset mid-MARK -> lamp=0 and busy=0 immediately (before the next edge). After release, push R -> normal .-. timing.
